// File: rtl/bmu_pipeline.sv
// Three-stage Hamming branch-metric pipeline for a K=3, rate-1/2 hard-decision Viterbi front end.
// Optional best-path search on stage 3 is enabled by defining BMU_BEST_PATH_EN.

package bmu_pipeline_pkg;
  // Expected code pair for shift-register contents {u, u1, u2}; MSB is the G1 bit.
  function automatic logic [1:0] enc_pair(input logic [2:0] g1, input logic [2:0] g2,
                                          input logic [2:0] sr);
    return {^(g1 & sr), ^(g2 & sr)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction
endpackage

module first_bmu
  import bmu_pipeline_pkg::*;
#(
  parameter logic [2:0] G1 = 3'b111,
  parameter logic [2:0] G2 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bit_pair_i,
  output logic [3:0] metrics_o,
  output logic       valid_o
);
  logic [3:0] metrics_d, metrics_q;
  logic       valid_q;

  // Step 1 starts from the all-zero state, so only the current input bit varies.
  always_comb begin
    metrics_d = '0;
    for (int a = 0; a < 2; a++)
      metrics_d[2*a +: 2] = hamming2(bit_pair_i, enc_pair(G1, G2, {1'(a), 2'b00}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      metrics_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      metrics_q <= metrics_d;
      valid_q   <= 1'b1;
    end
  end

  assign metrics_o = metrics_q;
  assign valid_o   = valid_q;
endmodule

module second_bmu
  import bmu_pipeline_pkg::*;
#(
  parameter logic [2:0] G1 = 3'b111,
  parameter logic [2:0] G2 = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bit_pair_i,
  input  logic [3:0]  metrics_i,
  input  logic        valid_i,
  output logic [11:0] metrics_o,
  output logic        valid_o
);
  logic [11:0] metrics_d, metrics_q;
  logic        valid_q;

  // Path index ab: a = i/2 (older input), b = i%2 (current input).
  always_comb begin
    metrics_d = metrics_q;
    if (valid_i) begin
      for (int i = 0; i < 4; i++)
        metrics_d[3*i +: 3] = 3'(metrics_i[2*(i/2) +: 2])
                            + 3'(hamming2(bit_pair_i, enc_pair(G1, G2, {1'(i), 1'(i/2), 1'b0})));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      metrics_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      metrics_q <= metrics_d;
      valid_q   <= valid_i;
    end
  end

  assign metrics_o = metrics_q;
  assign valid_o   = valid_q;
endmodule

module bmu
  import bmu_pipeline_pkg::*;
#(
  parameter logic [2:0] G1 = 3'b111,
  parameter logic [2:0] G2 = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bit_pair_i,
  input  logic [11:0] metrics_i,
  input  logic        valid_i,
  output logic [31:0] metrics_o,
  output logic        valid_o
`ifdef BMU_BEST_PATH_EN
  ,
  output logic [3:0]  best_metric_o,
  output logic [2:0]  best_path_o
`endif
);
  logic [31:0] metrics_d, metrics_q;
  logic        valid_q;

  // Path index abc: prefix ab = i/2, register contents {c, b, a}.
  always_comb begin
    metrics_d = metrics_q;
    if (valid_i) begin
      for (int i = 0; i < 8; i++)
        metrics_d[4*i +: 4] = 4'(metrics_i[3*(i/2) +: 3])
                            + 4'(hamming2(bit_pair_i,
                                          enc_pair(G1, G2, {1'(i), 1'(i/2), 1'(i/4)})));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      metrics_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      metrics_q <= metrics_d;
      valid_q   <= valid_i;
    end
  end

  assign metrics_o = metrics_q;
  assign valid_o   = valid_q;

`ifdef BMU_BEST_PATH_EN
  logic [3:0] best_metric_d, best_metric_q;
  logic [2:0] best_path_d, best_path_q;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_metric_d = best_metric_q;
    best_path_d   = best_path_q;
    if (valid_i) begin
      best_metric_d = metrics_d[3:0];
      best_path_d   = '0;
      for (int i = 1; i < 8; i++) begin
        if (metrics_d[4*i +: 4] < best_metric_d) begin
          best_metric_d = metrics_d[4*i +: 4];
          best_path_d   = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_metric_q <= '0;
      best_path_q   <= '0;
    end else begin
      best_metric_q <= best_metric_d;
      best_path_q   <= best_path_d;
    end
  end

  assign best_metric_o = best_metric_q;
  assign best_path_o   = best_path_q;
`endif
endmodule

module bmu_pipeline #(
  parameter logic [2:0] G1 = 3'b111,
  parameter logic [2:0] G2 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bit_pair_0,
  input  logic [1:0] bit_pair_1,
  input  logic [1:0] bit_pair_2,
  output logic [1:0] branch_metric_0,
  output logic [1:0] branch_metric_1,
  output logic       valid_1,
  output logic [2:0] branch_metric_00,
  output logic [2:0] branch_metric_01,
  output logic [2:0] branch_metric_10,
  output logic [2:0] branch_metric_11,
  output logic       valid_2,
  output logic [3:0] branch_metric_000,
  output logic [3:0] branch_metric_001,
  output logic [3:0] branch_metric_010,
  output logic [3:0] branch_metric_011,
  output logic [3:0] branch_metric_100,
  output logic [3:0] branch_metric_101,
  output logic [3:0] branch_metric_110,
  output logic [3:0] branch_metric_111,
  output logic       valid_3
`ifdef BMU_BEST_PATH_EN
  ,
  output logic [3:0] best_metric,
  output logic [2:0] best_path
`endif
);
  logic [3:0]  m1;
  logic [11:0] m2;
  logic [31:0] m3;
  logic        v1, v2, v3;

  first_bmu #(.G1(G1), .G2(G2)) u_s1 (
    .clk(clk), .rst(rst), .bit_pair_i(bit_pair_0), .metrics_o(m1), .valid_o(v1)
  );

  second_bmu #(.G1(G1), .G2(G2)) u_s2 (
    .clk(clk), .rst(rst), .bit_pair_i(bit_pair_1), .metrics_i(m1), .valid_i(v1),
    .metrics_o(m2), .valid_o(v2)
  );

  bmu #(.G1(G1), .G2(G2)) u_s3 (
    .clk(clk), .rst(rst), .bit_pair_i(bit_pair_2), .metrics_i(m2), .valid_i(v2),
    .metrics_o(m3), .valid_o(v3)
`ifdef BMU_BEST_PATH_EN
    , .best_metric_o(best_metric), .best_path_o(best_path)
`endif
  );

  assign branch_metric_0   = m1[1:0];
  assign branch_metric_1   = m1[3:2];
  assign valid_1           = v1;
  assign branch_metric_00  = m2[2:0];
  assign branch_metric_01  = m2[5:3];
  assign branch_metric_10  = m2[8:6];
  assign branch_metric_11  = m2[11:9];
  assign valid_2           = v2;
  assign branch_metric_000 = m3[3:0];
  assign branch_metric_001 = m3[7:4];
  assign branch_metric_010 = m3[11:8];
  assign branch_metric_011 = m3[15:12];
  assign branch_metric_100 = m3[19:16];
  assign branch_metric_101 = m3[23:20];
  assign branch_metric_110 = m3[27:24];
  assign branch_metric_111 = m3[31:28];
  assign valid_3           = v3;
endmodule

// File: tb/tb_bmu_pipeline.sv
// Self-checking bench for bmu_pipeline: fixed vectors, reset/refill sequences and random
// stimulus against a path-enumerating encoder model. Checks best path when BMU_BEST_PATH_EN.
module tb_bmu_pipeline;
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G2 = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bit_pair_0 = '0, bit_pair_1 = '0, bit_pair_2 = '0;
  logic [1:0] branch_metric_0, branch_metric_1;
  logic [2:0] branch_metric_00, branch_metric_01, branch_metric_10, branch_metric_11;
  logic [3:0] branch_metric_000, branch_metric_001, branch_metric_010, branch_metric_011;
  logic [3:0] branch_metric_100, branch_metric_101, branch_metric_110, branch_metric_111;
  logic       valid_1, valid_2, valid_3;
`ifdef BMU_BEST_PATH_EN
  logic [3:0] best_metric;
  logic [2:0] best_path;
`endif

  bmu_pipeline dut (
    .clk(clk), .rst(rst),
    .bit_pair_0(bit_pair_0), .bit_pair_1(bit_pair_1), .bit_pair_2(bit_pair_2),
    .branch_metric_0(branch_metric_0), .branch_metric_1(branch_metric_1), .valid_1(valid_1),
    .branch_metric_00(branch_metric_00), .branch_metric_01(branch_metric_01),
    .branch_metric_10(branch_metric_10), .branch_metric_11(branch_metric_11), .valid_2(valid_2),
    .branch_metric_000(branch_metric_000), .branch_metric_001(branch_metric_001),
    .branch_metric_010(branch_metric_010), .branch_metric_011(branch_metric_011),
    .branch_metric_100(branch_metric_100), .branch_metric_101(branch_metric_101),
    .branch_metric_110(branch_metric_110), .branch_metric_111(branch_metric_111),
    .valid_3(valid_3)
`ifdef BMU_BEST_PATH_EN
    , .best_metric(best_metric), .best_path(best_path)
`endif
  );

  always #5 clk = ~clk;

  logic [1:0] a1 [2];
  logic [2:0] a2 [4];
  logic [3:0] a3 [8];
  assign a1[0] = branch_metric_0;   assign a1[1] = branch_metric_1;
  assign a2[0] = branch_metric_00;  assign a2[1] = branch_metric_01;
  assign a2[2] = branch_metric_10;  assign a2[3] = branch_metric_11;
  assign a3[0] = branch_metric_000; assign a3[1] = branch_metric_001;
  assign a3[2] = branch_metric_010; assign a3[3] = branch_metric_011;
  assign a3[4] = branch_metric_100; assign a3[5] = branch_metric_101;
  assign a3[6] = branch_metric_110; assign a3[7] = branch_metric_111;

  int checks = 0;
  int errors = 0;

  // Per-edge history of what the DUT sampled.
  bit         rst_h [$];
  logic [1:0] p0_h [$];
  logic [1:0] p1_h [$];
  logic [1:0] p2_h [$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [1:0] enc_out(input int u, input int s1, input int s2);
    logic [2:0] st;
    st = {1'(u), 1'(s1), 1'(s2)};
    return {^(G1 & st), ^(G2 & st)};
  endfunction

  // A stage-k result is valid when the last k edges all saw rst low.
  function automatic bit stage_valid(input int k);
    int n;
    n = rst_h.size() - 1;
    if (n - k + 1 < 0) return 1'b0;
    for (int i = 0; i < k; i++)
      if (rst_h[n-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Run an encoder along path p (k bits, MSB oldest) and sum Hamming distances.
  function automatic int model(input int k, input int p);
    int n, s1, s2, m, u, e;
    logic [1:0] rx;
    if (!stage_valid(k)) return 0;
    n = rst_h.size() - 1;
    s1 = 0; s2 = 0; m = 0;
    for (int j = 0; j < k; j++) begin
      u  = (p >> (k - 1 - j)) & 1;
      e  = n - (k - 1 - j);
      rx = (j == 0) ? p0_h[e] : (j == 1) ? p1_h[e] : p2_h[e];
      m += $countones(rx ^ enc_out(u, s1, s2));
      s2 = s1;
      s1 = u;
    end
    return m;
  endfunction

  task automatic check_model();
    chk("valid_1", int'(valid_1), int'(stage_valid(1)));
    chk("valid_2", int'(valid_2), int'(stage_valid(2)));
    chk("valid_3", int'(valid_3), int'(stage_valid(3)));
    for (int i = 0; i < 2; i++) chk($sformatf("bm1_%0d", i), int'(a1[i]), model(1, i));
    for (int i = 0; i < 4; i++) chk($sformatf("bm2_%0d", i), int'(a2[i]), model(2, i));
    for (int i = 0; i < 8; i++) chk($sformatf("bm3_%0d", i), int'(a3[i]), model(3, i));
`ifdef BMU_BEST_PATH_EN
    begin
      int em, ep;
      em = model(3, 0); ep = 0;
      for (int i = 1; i < 8; i++)
        if (model(3, i) < em) begin em = model(3, i); ep = i; end
      chk("best_metric", int'(best_metric), em);
      chk("best_path", int'(best_path), ep);
    end
`endif
  endtask

  task automatic cycle(input bit r, input logic [1:0] q0, input logic [1:0] q1, input logic [1:0] q2);
    rst = r; bit_pair_0 = q0; bit_pair_1 = q1; bit_pair_2 = q2;
    @(posedge clk);
    rst_h.push_back(r); p0_h.push_back(q0); p1_h.push_back(q1); p2_h.push_back(q2);
    #1;
    check_model();
  endtask

  task automatic refill_check(input string tag);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 2'($urandom), 2'($urandom), 2'($urandom));
      chk($sformatf("%s_v1_e%0d", tag, k), int'(valid_1), 1);
      chk($sformatf("%s_v2_e%0d", tag, k), int'(valid_2), int'(k >= 2));
      chk($sformatf("%s_v3_e%0d", tag, k), int'(valid_3), int'(k >= 3));
    end
  endtask

  typedef struct packed {
    logic [1:0]      p0, p1, p2;
    logic [1:0][1:0] e1;
    logic [3:0][2:0] e2;
    logic [7:0][3:0] e3;
    logic [3:0]      bm;
    logic [2:0]      bp;
  } vec_t;

  vec_t tbl [3];

  initial begin
    // Packed arrays list the highest index first.
    tbl[0] = '{p0: 2'b00, p1: 2'b00, p2: 2'b00, e1: {2'd2, 2'd0},
               e2: {3'd3, 3'd3, 3'd2, 3'd0},
               e3: {4'd4, 4'd4, 4'd3, 4'd5, 4'd3, 4'd3, 4'd2, 4'd0}, bm: 4'd0, bp: 3'd0};
    tbl[1] = '{p0: 2'b11, p1: 2'b11, p2: 2'b11, e1: {2'd0, 2'd2},
               e2: {3'd1, 3'd1, 3'd2, 3'd4},
               e3: {4'd2, 4'd2, 4'd3, 4'd1, 4'd3, 4'd3, 4'd4, 4'd6}, bm: 4'd1, bp: 3'd4};
    tbl[2] = '{p0: 2'b01, p1: 2'b10, p2: 2'b01, e1: {2'd1, 2'd1},
               e2: {3'd3, 3'd1, 3'd2, 3'd2},
               e3: {4'd5, 4'd3, 4'd2, 4'd2, 4'd2, 4'd4, 4'd3, 4'd3}, bm: 4'd2, bp: 3'd3};

    for (int i = 0; i < 10; i++) cycle(1'b1, 2'($urandom), 2'($urandom), 2'($urandom));
    refill_check("startup");

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 3; k++) cycle(1'b0, tbl[t].p0, tbl[t].p1, tbl[t].p2);
      for (int i = 0; i < 2; i++) chk($sformatf("tbl%0d_bm1_%0d", t, i), int'(a1[i]), int'(tbl[t].e1[i]));
      for (int i = 0; i < 4; i++) chk($sformatf("tbl%0d_bm2_%0d", t, i), int'(a2[i]), int'(tbl[t].e2[i]));
      for (int i = 0; i < 8; i++) chk($sformatf("tbl%0d_bm3_%0d", t, i), int'(a3[i]), int'(tbl[t].e3[i]));
`ifdef BMU_BEST_PATH_EN
      chk($sformatf("tbl%0d_best_metric", t), int'(best_metric), int'(tbl[t].bm));
      chk($sformatf("tbl%0d_best_path", t), int'(best_path), int'(tbl[t].bp));
`endif
    end

    // Mid-stream reset: everything clears on the first reset edge.
    cycle(1'b1, 2'b11, 2'b11, 2'b11);
    chk("midrst_v1", int'(valid_1), 0);
    chk("midrst_v2", int'(valid_2), 0);
    chk("midrst_v3", int'(valid_3), 0);
    for (int i = 0; i < 2; i++) chk($sformatf("midrst_bm1_%0d", i), int'(a1[i]), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_bm2_%0d", i), int'(a2[i]), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst_bm3_%0d", i), int'(a3[i]), 0);
    cycle(1'b1, 2'b10, 2'b01, 2'b11);
    refill_check("refill");

    for (int n = 0; n < 1000; n++) begin
      cycle(bit'($urandom_range(0, 127) == 0), 2'($urandom), 2'($urandom), 2'($urandom));
      for (int i = 0; i < 2; i++) chk("range_bm1", int'(a1[i] <= 2'd2), 1);
      for (int i = 0; i < 4; i++) chk("range_bm2", int'(a2[i] <= 3'd4), 1);
      for (int i = 0; i < 8; i++) chk("range_bm3", int'(a3[i] <= 4'd6), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bmu_pipeline.md
Name: bmu_pipeline

Overview:
- Three-stage registered branch-metric unit for a rate-1/2 hard-decision Viterbi decoder (constraint length 3).
- Accumulates Hamming-distance path metrics over the first three trellis steps from the all-zero start state:
  - 2 paths after stage 1.
  - 4 paths after stage 2.
  - 8 paths after stage 3.
- Top wrapper chains three submodules: first_bmu, then second_bmu, then bmu. Each stage has a valid flag.
- Feeds the first ACS/survivor stage.

Parameters:
- G1, 3'b111: generator polynomial for the output MSB. Bit 2 = current input, bit 0 = input two steps back.
- G2, 3'b101: generator polynomial for the output LSB, same bit ordering.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- bit_pair_0  in  2  received code pair for step 1; MSB is the G1 bit.
- bit_pair_1  in  2  received code pair for step 2.
- bit_pair_2  in  2  received code pair for step 3.
- branch_metric_0, branch_metric_1  out  2 each  step-1 path metrics, indexed by input bit a.
- valid_1  out  1  stage-1 outputs valid.
- branch_metric_00 … branch_metric_11  out  3 each  step-2 metrics, index ab (a = oldest input).
- valid_2  out  1  stage-2 outputs valid.
- branch_metric_000 … branch_metric_111  out  4 each  step-3 metrics, index abc.
- valid_3  out  1  stage-3 outputs valid.

Behaviour:
- Expected encoder output for a path:
  - exp(u, u1, u2) = { parity(G1 & {u,u1,u2}), parity(G2 & {u,u1,u2}) }.
  - u = current input, u1 and u2 = previous inputs, zero before step 1.
- hd(x, y) = number of differing bits, range 0..2.
- Stage 1 (first_bmu), every clock with rst=0:
  - bm_a <= hd(bit_pair_0, exp(a,0,0)).
  - valid_1 <= 1.
- Stage 2 (second_bmu), on a clock with valid_in=1:
  - bm_ab <= bm_a + hd(bit_pair_1, exp(b,a,0)).
  - valid_2 <= 1.
- Stage 3 (bmu), on a clock with valid_in=1:
  - bm_abc <= bm_ab + hd(bit_pair_2, exp(c,b,a)).
  - valid_3 <= 1.
- When valid_in=0 in stage 2 or 3: metric registers hold their value and valid_out <= 0.
- Each bit_pair_k is sampled at the same edge its stage registers. Stage k uses the previous stage's registered metrics together with the current bit_pair_k.
- Width: zero-extend before adding. Max values are 2/4/6, so no overflow is possible and no saturation is needed.
- Latency: valid_1 rises at the first edge sampling rst=0. valid_2 follows 1 cycle later, valid_3 2 cycles later. All three then stay high while rst=0.
- Reset (also mid-operation): at any edge with rst=1, every metric and every valid clears to 0. The pipeline refills as at startup.
- rst has priority over valid_in.

Optional Feature:
- Macro: BMU_BEST_PATH_EN.
- When defined, adds two outputs, registered with stage 3 and updated only when stage 3 updates:
  - best_metric (4 bits): minimum of the eight step-3 metrics.
  - best_path (3 bits): index abc of that minimum; lowest index wins a tie.
- Both reset to 0.
- When undefined, these ports and their logic do not exist.

Test Plan:
- Reset 10 cycles, then check the startup sequence:
  - All outputs 0 during reset.
  - After release, valid_1/valid_2/valid_3 rise on edges 1/2/3.
- All pairs held at 00 until valid_3=1:
  - bm0=0, bm1=2.
  - bm00..11 = 0,2,3,3.
  - bm000..111 = 0,2,3,3,5,3,4,4.
- All pairs held at 11:
  - bm0=2, bm1=0.
  - bm00..11 = 4,2,1,1.
  - bm000..111 = 6,4,3,3,1,3,2,2.
  - With BMU_BEST_PATH_EN: best_metric=1, best_path=100.
- Pairs (01,10,01):
  - bm0=1, bm1=1.
  - bm00..11 = 2,2,1,3.
  - Verify the eight step-3 metrics against a reference model.
- Reset asserted for 2 cycles mid-stream:
  - All outputs and valids are 0 at the first reset edge.
  - Refill latency after release is identical to startup.
- Random bit pairs for 1000 cycles vs a behavioural model: no mismatch, all metrics ≤ 2/4/6.
